// File: rtl/imem_loader.sv
// Instruction-memory writer: takes a byte stream (16-bit LE word count, then LE words)
// and writes word-aligned instructions, holding the core until the load completes.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | after reset, waiting for start
//  LEN_LO  | waiting for low byte of word count
//  LEN_HI  | waiting for high byte of word count, header checked here
//  DATA    | collecting 4 bytes of the current instruction word
//  WRITE   | one-cycle write strobe, word_count advances
//  DONE    | load complete, core released
//  ERROR   | illegal header, core kept in hold
module imem_loader #(
   parameter int DEPTH = 256,
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERROR
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] len;
   logic [1:0]  lane;
   logic        xfer;
   logic [15:0] len_full;
   logic [15:0] wc_inc;
   logic        len_bad;
   logic        can_start;

   assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
   assign xfer       = byte_valid && byte_ready;
   assign len_full   = {byte_data, len[7:0]};
   assign wc_inc     = 16'(word_count) + 16'd1;
   assign len_bad    = (len_full == 16'd0) || (len_full > 16'(DEPTH));
   assign can_start  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

   assign busy     = byte_ready || (state == S_WRITE);
   // ERROR keeps the core held so a partial image never runs
   assign cpu_hold = busy || (state == S_ERROR);
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERROR);
   assign mem_we   = (state == S_WRITE);
   assign mem_addr = {{(30-CNT_W){1'b0}}, word_count, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_LO;
         S_LEN_LO: if (byte_valid) state_nxt = S_LEN_HI;
         S_LEN_HI: if (byte_valid) state_nxt = len_bad ? S_ERROR : S_DATA;
         S_DATA:   if (byte_valid && (lane == 2'd3)) state_nxt = S_WRITE;
         S_WRITE:  state_nxt = (wc_inc == len) ? S_DONE : S_DATA;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len        <= '0;
         lane       <= '0;
         word_count <= '0;
         mem_wdata  <= '0;
      end else begin
         if (can_start && start) word_count <= '0;
         if (state == S_LEN_LO && xfer) len[7:0] <= byte_data;
         if (state == S_LEN_HI && xfer) begin
            len[15:8] <= byte_data;
            lane      <= 2'd0;
         end
         if (state == S_DATA && xfer) begin
            mem_wdata[{lane, 3'b000} +: 8] <= byte_data;
            lane                           <= lane + 2'd1;
         end
         if (state == S_WRITE) begin
            word_count <= wc_inc[CNT_W-1:0];
            lane       <= 2'd0;
         end
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream and writes it into the instruction memory write port as word-aligned 32-bit instructions.
- Holds the core in hold (cpu_hold) for the whole load, releasing it only when the load completes.
- Sits between the host byte link (UART RX or debug bridge) and the instruction memory.
- Stream format: 2-byte little-endian word count N, then N instructions, 4 bytes each, little-endian.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; the maximum legal N.
- CNT_W, 9, width of word counters; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_data  in  8  incoming stream byte.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle; a byte transfers when byte_valid && byte_ready.
- mem_we  out  1  single-cycle write strobe to the instruction memory.
- mem_addr  out  32  byte address of the write, always word aligned (word_index << 2).
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  core must not fetch or retire while high.
- busy  out  1  load in progress.
- done  out  1  sticky: last load completed successfully.
- error  out  1  sticky: last load aborted on an illegal header.
- word_count  out  CNT_W  words written so far in the current or last load.

Behaviour:
- Reset (async, rst_n low): state IDLE.
  - byte_ready, mem_we, cpu_hold, busy, done and error are 0.
  - mem_addr, mem_wdata and word_count are 0.
  - The byte-lane counter and the length register are cleared.
- States are IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE and ERROR.
- IDLE/DONE/ERROR with start=1:
  - Go to LEN_LO.
  - Clear done, error and word_count.
  - Set busy=1 and cpu_hold=1 from the next cycle.
- start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- byte_ready=1 only in LEN_LO, LEN_HI and DATA. It is combinational from state and is 0 in all other states.
- LEN_LO: on a transfer, len[7:0] = byte_data, then go to LEN_HI.
- LEN_HI: on a transfer, len[15:8] = byte_data.
  - If the 16-bit len is 0 or greater than DEPTH, go to ERROR.
  - Otherwise go to DATA with lane=0.
- DATA: each transfer stores the byte into mem_wdata lane `lane` (lane 0 = bits 7:0, lane 3 = bits 31:24), then lane increments.
  - On the transfer with lane=3, go to WRITE.
  - Cycles without byte_valid insert no state change and lose no data.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr = word_count << 2, and mem_wdata holds the full word.
  - word_count increments at the end of the cycle.
  - If the incremented word_count equals len, go to DONE; otherwise go to DATA with lane=0.
  - byte_ready=0 in this cycle (1-cycle bubble per word).
- DONE: busy=0, cpu_hold=0, done=1. word_count holds N.
- ERROR: busy=0, error=1. cpu_hold stays 1 so the core never runs a partial image. Only start or reset leaves ERROR.
- mem_we is never high outside WRITE. At most N writes occur per load.
- Addresses run 0x0, 0x4, … up to (N-1)*4.
- Throughput: at most one word per 5 cycles (4 byte cycles plus 1 WRITE).
- Reset mid-load:
  - Immediate return to IDLE and cpu_hold drops.
  - Memory words already written stay in memory; the loader does not scrub them.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them (standard valid/ready rule).

Test Plan:
- Load N=3 with continuous valid. Stream 03 00 | B3 00 00 00 | B3 80 10 00 | 33 82 21 40 -> exactly 3 mem_we pulses:
  - (0x0, 0x000000B3)
  - (0x4, 0x001080B3)
  - (0x8, 0x40218233)
  - then done=1, word_count=3, cpu_hold=0.
- Throttled source: same N=3 stream with byte_valid toggling 1/0 and random 0–3-cycle gaps -> identical writes and values. No byte is consumed while byte_ready=0, including the WRITE-cycle bubble.
- Illegal header 00 00 -> error=1, no mem_we, cpu_hold=1, byte_ready=0. Header 01 01 (257) -> same. A following start plus a valid N=1 load clears error and ends with done=1.
- Full depth: N=256 (00 01) with sequential word values i -> 256 writes.
  - Last write is at address 0x3FC.
  - word_count=256, done=1.
- Reset mid-load:
  - Assert rst_n=0 after 2 of 4 words. Outputs return to reset values asynchronously and no further mem_we occurs.
  - A new start plus N=1 writes at address 0x0.
- Pulse start during DATA -> ignored: no counter clear, and the load completes normally with the original N.
